// File: rtl/controller_link_tx.sv
// rtl/controller_link_tx.sv - serial transmitter for 7-bit controller input frames with one-entry holding buffer
module controller_link_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] frame_data,
  input  logic       frame_valid,
  output logic       frame_ready,
  output logic       tx,
  output logic       busy
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_IDX = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic [6:0]    hold_data;
  logic          hold_valid;
  logic          load;
  logic          bit_end;

  assign frame_ready = !hold_valid && !rst;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign bit_end     = (cnt_q == CNT_MAX);

  // Holding register: captures an offered frame, released when the shifter loads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 7'd0;
    end else if (load) begin
      hold_valid <= 1'b0;
    end else if (frame_valid && frame_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= frame_data;
    end
  end

  // Shifter state register, including the registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 7'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: bit timing, data shifting and frame chaining from the holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;

    if (state_q == IDLE) begin
      tx_d  = 1'b1;
      cnt_d = '0;
      idx_d = 3'd0;
      load  = hold_valid;
    end else if (!bit_end) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
        DATA: begin
          if (idx_q == 3'd6) begin
            idx_d = 3'd0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
        PARITY: begin
          state_d = STOP;
          idx_d   = 3'd0;
          tx_d    = 1'b1;
        end
        STOP: begin
          if (idx_q == STOP_IDX) begin
            // Chain straight into the queued frame so no idle clock separates them.
            load    = hold_valid;
            state_d = IDLE;
            idx_d   = 3'd0;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    if (load) begin
      shift_d = hold_data;
      par_d   = ^hold_data;
      state_d = START;
      cnt_d   = '0;
      idx_d   = 3'd0;
      tx_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller_link_tx.sv
// tb/tb_controller_link_tx.sv - randomized self-checking bench for controller_link_tx against a frame-level model
module tb_controller_link_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [6:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic       tx;
  logic       busy;
  logic [6:0] frame_data2;
  logic       frame_valid2;
  logic       frame_ready2;
  logic       tx2;
  logic       busy2;

  int checks;
  int failures;

  logic exp_q[$];
  logic got_q[$];

  controller_link_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .tx(tx), .busy(busy)
  );

  controller_link_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .frame_data(frame_data2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready2), .tx(tx2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input int s);
    return (s != 0) ? tx2 : tx;
  endfunction

  function automatic logic get_busy(input int s);
    return (s != 0) ? busy2 : busy;
  endfunction

  function automatic logic get_ready(input int s);
    return (s != 0) ? frame_ready2 : frame_ready;
  endfunction

  task automatic drive(input int s, input logic [6:0] d, input logic v);
    if (s != 0) begin
      frame_data2  = d;
      frame_valid2 = v;
    end else begin
      frame_data  = d;
      frame_valid = v;
    end
  endtask

  // Expected line level, one entry per clock, for a whole frame.
  function automatic void push_frame(input logic [6:0] d, input int pe, input int sb);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 7; i++) bits.push_back(d[i]);
    if (pe != 0) bits.push_back(logic'($countones(d) % 2));
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 7'd0, 1'b0);
    drive(1, 7'd0, 1'b0);
    tick();
    tick();
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", frame_ready); end
    checks++; if (tx2 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_dut2: got tx=%b busy=%b expected tx=1 busy=0", tx2, busy2); end
    rst = 1'b0;
    #1;
    checks++; if (frame_ready !== 1'b1 || frame_ready2 !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b/%b expected 1/1", frame_ready, frame_ready2); end
  endtask

  task automatic test_idle_frame(input int s, input logic [6:0] d);
    int pe;
    int sb;
    int len;
    int bad_tx;
    int bad_busy;
    int first_bad;
    pe = (s != 0) ? 0 : 1;
    sb = (s != 0) ? 2 : 1;
    len = (8 + pe + sb) * CPB;
    exp_q.delete();
    got_q.delete();
    push_frame(d, pe, sb);
    drive(s, d, 1'b1);
    #1;
    checks++; if (get_ready(s) !== 1'b1) begin failures++; $display("FAIL idle_ready_before: got %b expected 1", get_ready(s)); end
    tick();
    drive(s, 7'($urandom), 1'b0);
    checks++; if (get_tx(s) !== 1'b1 || get_ready(s) !== 1'b0) begin failures++; $display("FAIL idle_after_accept: got tx=%b ready=%b expected tx=1 ready=0", get_tx(s), get_ready(s)); end
    bad_tx = 0; bad_busy = 0; first_bad = -1;
    for (int k = 1; k <= len; k++) begin
      tick();
      drive(s, 7'($urandom), 1'b0);
      got_q.push_back(get_tx(s));
      if (k == 1) begin
        checks++; if (get_tx(s) !== 1'b0 || get_ready(s) !== 1'b1) begin failures++; $display("FAIL idle_start_latency: got tx=%b ready=%b expected tx=0 ready=1", get_tx(s), get_ready(s)); end
      end
      if (get_tx(s) !== exp_q[k-1]) begin bad_tx++; if (first_bad < 0) first_bad = k; end
      if (get_busy(s) !== 1'b1) bad_busy++;
    end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL idle_waveform data=%b: %0d clock(s) wrong, first at clock %0d, expected 0", d, bad_tx, first_bad); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL idle_busy data=%b: got %0d low clock(s) expected 0", d, bad_busy); end
    tick();
    checks++; if (get_tx(s) !== 1'b1 || get_busy(s) !== 1'b0) begin failures++; $display("FAIL idle_end: got tx=%b busy=%b expected tx=1 busy=0", get_tx(s), get_busy(s)); end
  endtask

  task automatic test_parity();
    test_idle_frame(0, 7'b0000111);
    checks++; if (got_q[32] !== 1'b1) begin failures++; $display("FAIL parity_0000111: got %b expected 1", got_q[32]); end
    test_idle_frame(0, 7'b0000000);
    checks++; if (got_q[32] !== 1'b0) begin failures++; $display("FAIL parity_0000000: got %b expected 0", got_q[32]); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] c;
    int bad_tx;
    int bad_busy;
    int bad_ready;
    int first_bad;
    a = 7'($urandom);
    b = 7'h7f;
    c = 7'($urandom);
    exp_q.delete();
    got_q.delete();
    push_frame(a, 1, 1);
    push_frame(b, 1, 1);
    for (int i = 0; i < 10; i++) exp_q.push_back(1'b1);
    drive(0, a, 1'b1);
    tick();
    drive(0, 7'($urandom), 1'b0);
    bad_tx = 0; bad_busy = 0; bad_ready = 0; first_bad = -1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      tick();
      got_q.push_back(tx);
      if (tx !== exp_q[cyc-1]) begin bad_tx++; if (first_bad < 0) first_bad = cyc; end
      if (busy !== ((cyc <= 80) ? 1'b1 : 1'b0)) bad_busy++;
      if (cyc == 10) begin
        checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_empty: got %b expected 1", frame_ready); end
        drive(0, b, 1'b1);
      end else if (cyc == 11) begin
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accepted: got ready=%b expected 0", frame_ready); end
        drive(0, c, 1'b1);
      end else if (cyc >= 12 && cyc <= 20) begin
        if (frame_ready !== 1'b0) bad_ready++;
        if (cyc == 20) drive(0, 7'($urandom), 1'b0);
        else drive(0, 7'($urandom), 1'b1);
      end else if (cyc == 40) begin
        checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_before_load: got %b expected 0", frame_ready); end
      end else if (cyc == 41) begin
        checks++; if (frame_ready !== 1'b1 || tx !== 1'b0) begin failures++; $display("FAIL b2b_chain: got ready=%b tx=%b expected ready=1 tx=0", frame_ready, tx); end
      end
    end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL backpressure_ready: got %0d high clock(s) expected 0", bad_ready); end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL b2b_waveform: %0d clock(s) wrong, first at clock %0d, expected 0", bad_tx, first_bad); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL b2b_busy: got %0d wrong clock(s) expected 0", bad_busy); end
    checks++; if (got_q[72] !== 1'b1) begin failures++; $display("FAIL b2b_parity_1111111: got %b expected 1", got_q[72]); end
    test_idle_frame(0, c);
  endtask

  task automatic test_reset_mid();
    logic [6:0] a;
    int bad_tx;
    int bad_idle;
    a = 7'($urandom);
    exp_q.delete();
    push_frame(a, 1, 1);
    drive(0, a, 1'b1);
    tick();
    drive(0, 7'($urandom), 1'b0);
    bad_tx = 0;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      tick();
      if (cyc <= 20 && tx !== exp_q[cyc-1]) bad_tx++;
      if (cyc == 10) drive(0, 7'($urandom), 1'b1);
      if (cyc == 11) drive(0, 7'($urandom), 1'b0);
      if (cyc == 20) rst = 1'b1;
    end
    checks++; if (bad_tx != 0) begin failures++; $display("FAIL rstmid_pre_waveform: %0d clock(s) wrong expected 0", bad_tx); end
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || frame_ready !== 1'b0) begin failures++; $display("FAIL rstmid_abort: got tx=%b busy=%b ready=%b expected 1/0/0", tx, busy, frame_ready); end
    rst = 1'b0;
    #1;
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL rstmid_queue_cleared: got ready=%b expected 1", frame_ready); end
    bad_idle = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad_idle++;
    end
    checks++; if (bad_idle != 0) begin failures++; $display("FAIL rstmid_queued_lost: got %0d active clock(s) expected 0", bad_idle); end
    test_idle_frame(0, 7'($urandom));
  endtask

  task automatic test_config();
    test_idle_frame(1, 7'b1010101);
    checks++; if (got_q[32] !== 1'b1 || got_q[28] !== 1'b1) begin failures++; $display("FAIL config_no_parity: got bit8=%b bit7=%b expected 1/1", got_q[32], got_q[28]); end
    test_idle_frame(1, 7'($urandom));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    frame_data = 7'd0;
    frame_valid = 1'b0;
    frame_data2 = 7'd0;
    frame_valid2 = 1'b0;
    test_reset();
    test_idle_frame(0, 7'b0000101);
    test_parity();
    for (int i = 0; i < 4; i++) test_idle_frame(0, 7'($urandom));
    test_back_to_back();
    test_reset_mid();
    test_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
